// File: rtl/core_axi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// core_axi_arbiter_pkg
// Shared definitions for the instruction/data AXI4-Lite arbiter:
//   - arb_state_t : arbiter FSM state encoding
//   - GRANT_*     : codes presented on the GRANT output
//   - RESP_*      : AXI response codes used by the arbiter and its users
//   - helper functions that classify a grant code
// No ports (package).
// -----------------------------------------------------------------------------
package core_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WRESP = 3'd4
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE   = 2'b00;
  localparam logic [1:0] GRANT_INSTR  = 2'b01;
  localparam logic [1:0] GRANT_DREAD  = 2'b10;
  localparam logic [1:0] GRANT_DWRITE = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Both data-side grant codes have bit 1 set.
  function automatic logic is_data_grant(input logic [1:0] g);
    return g[1];
  endfunction

  function automatic logic is_write_grant(input logic [1:0] g);
    return (g == GRANT_DWRITE);
  endfunction

endpackage

// File: rtl/core_arb_pick.sv
// -----------------------------------------------------------------------------
// core_arb_pick
// Purely combinational winner selection for core_axi_arbiter.
// A data write (address and data both valid) always beats a data read.
// Between the data class and instruction fetch:
//   ARB_ROUND_ROBIN_EN undefined : data always wins (fixed priority).
//   ARB_ROUND_ROBIN_EN defined   : on a collision the class not granted last
//                                  wins; last_data tells which class that was.
// Ports:
//   last_data (RR build only) : 1 = previous grant went to the data class
//   i_req                     : instruction fetch request
//   d_rd_req                  : data read request
//   d_wr_req                  : data write request (AW and W both valid)
//   pick                      : winning GRANT_* code, GRANT_NONE if idle
// -----------------------------------------------------------------------------
module core_arb_pick
  import core_axi_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last_data,
`endif
  input  logic       i_req,
  input  logic       d_rd_req,
  input  logic       d_wr_req,
  output logic [1:0] pick
);

  logic       d_any;
  logic [1:0] d_pick;

  always_comb begin
    d_any  = d_rd_req | d_wr_req;
    d_pick = GRANT_NONE;
    if (d_wr_req) begin
      d_pick = GRANT_DWRITE;
    end else if (d_rd_req) begin
      d_pick = GRANT_DREAD;
    end
  end

  always_comb begin
    pick = GRANT_NONE;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_any && i_req) begin
      pick = last_data ? GRANT_INSTR : d_pick;
    end else if (d_any) begin
      pick = d_pick;
    end else if (i_req) begin
      pick = GRANT_INSTR;
    end
`else
    if (d_any) begin
      pick = d_pick;
    end else if (i_req) begin
      pick = GRANT_INSTR;
    end
`endif
  end

endmodule

// File: rtl/core_axi_arbiter.sv
// -----------------------------------------------------------------------------
// core_axi_arbiter
// Arbitrates an instruction-fetch read port and a data read/write port onto a
// single AXI4-Lite master port with exactly one outstanding transaction.
// The winner and its address/data/strobe are latched in S_IDLE, so requester
// inputs may change freely while BUSY without disturbing the M port.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin between the
// instruction and data classes; default build is fixed data-first priority).
// Ports:
//   CLK, NRST            : clock, asynchronous active-low reset
//   I_AR*, I_R*          : instruction fetch read address / read data
//   D_AR*, D_R*          : data load read address / read data
//   D_AW*, D_W*, D_B*    : data store write address / data / response
//   M_AR*, M_R*, M_AW*,
//   M_W*, M_B*           : shared AXI4-Lite master port to memory
//   GRANT                : 00 none, 01 instruction, 10 data read, 11 data write
//   BUSY                 : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module core_axi_arbiter
  import core_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                NRST,
  // instruction fetch
  input  logic                I_ARVALID,
  input  logic [ADDR_W-1:0]   I_ARADDR,
  output logic                I_ARREADY,
  output logic                I_RVALID,
  output logic [DATA_W-1:0]   I_RDATA,
  output logic [1:0]          I_RRESP,
  input  logic                I_RREADY,
  // data read
  input  logic                D_ARVALID,
  input  logic [ADDR_W-1:0]   D_ARADDR,
  output logic                D_ARREADY,
  output logic                D_RVALID,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic [1:0]          D_RRESP,
  input  logic                D_RREADY,
  // data write
  input  logic                D_AWVALID,
  input  logic [ADDR_W-1:0]   D_AWADDR,
  output logic                D_AWREADY,
  input  logic                D_WVALID,
  input  logic [DATA_W-1:0]   D_WDATA,
  input  logic [DATA_W/8-1:0] D_WSTRB,
  output logic                D_WREADY,
  output logic                D_BVALID,
  output logic [1:0]          D_BRESP,
  input  logic                D_BREADY,
  // shared master port
  output logic                M_ARVALID,
  output logic [ADDR_W-1:0]   M_ARADDR,
  input  logic                M_ARREADY,
  input  logic                M_RVALID,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  output logic                M_RREADY,
  output logic                M_AWVALID,
  output logic [ADDR_W-1:0]   M_AWADDR,
  input  logic                M_AWREADY,
  output logic                M_WVALID,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  input  logic                M_WREADY,
  input  logic                M_BVALID,
  input  logic [1:0]          M_BRESP,
  output logic                M_BREADY,
  // status
  output logic [1:0]          GRANT,
  output logic                BUSY
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t        state_reg, state_next;
  logic [1:0]        grant_reg, grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0] wstrb_reg, wstrb_next;
  logic              aw_done_reg, aw_done_next;
  logic              w_done_reg, w_done_next;

  logic [1:0]        pick;
  logic              rready_sel;
  logic              aw_done_now;
  logic              w_done_now;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_data_reg, last_data_next;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  core_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .last_data (last_data_reg),
`endif
    .i_req     (I_ARVALID),
    .d_rd_req  (D_ARVALID),
    .d_wr_req  (D_AWVALID & D_WVALID),
    .pick      (pick)
  );

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_reg   <= S_IDLE;
      grant_reg   <= GRANT_NONE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset value 0 means "last grant was instruction".
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      last_data_reg <= 1'b0;
    end else begin
      last_data_reg <= last_data_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic and channel muxing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_next = last_data_reg;
`endif

    I_ARREADY = 1'b0;
    I_RVALID  = 1'b0;
    I_RDATA   = '0;
    I_RRESP   = RESP_OKAY;
    D_ARREADY = 1'b0;
    D_RVALID  = 1'b0;
    D_RDATA   = '0;
    D_RRESP   = RESP_OKAY;
    D_AWREADY = 1'b0;
    D_WREADY  = 1'b0;
    D_BVALID  = 1'b0;
    D_BRESP   = RESP_OKAY;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;

    rready_sel  = 1'b0;
    aw_done_now = 1'b0;
    w_done_now  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Latch only; no requester sees READY in this cycle.
        if (pick != GRANT_NONE) begin
          grant_next = pick;
          case (pick)
            GRANT_INSTR: addr_next = I_ARADDR;
            GRANT_DREAD: addr_next = D_ARADDR;
            default:     addr_next = D_AWADDR;
          endcase
          if (is_write_grant(pick)) begin
            wdata_next = D_WDATA;
            wstrb_next = D_WSTRB;
            state_next = S_WADDR;
          end else begin
            state_next = S_RADDR;
          end
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_next = is_data_grant(pick);
`endif
        end
      end

      S_RADDR: begin
        M_ARVALID = 1'b1;
        if (grant_reg == GRANT_INSTR) begin
          I_ARREADY = M_ARREADY;
        end else begin
          D_ARREADY = M_ARREADY;
        end
        if (M_ARREADY) begin
          state_next = S_RDATA;
        end
      end

      S_RDATA: begin
        if (grant_reg == GRANT_INSTR) begin
          I_RVALID   = M_RVALID;
          I_RDATA    = M_RDATA;
          I_RRESP    = M_RRESP;
          rready_sel = I_RREADY;
        end else begin
          D_RVALID   = M_RVALID;
          D_RDATA    = M_RDATA;
          D_RRESP    = M_RRESP;
          rready_sel = D_RREADY;
        end
        M_RREADY = rready_sel;
        if (M_RVALID && rready_sel) begin
          state_next = S_IDLE;
          grant_next = GRANT_NONE;
        end
      end

      S_WADDR: begin
        // AW and W complete independently; each is offered until accepted.
        M_AWVALID   = !aw_done_reg;
        M_WVALID    = !w_done_reg;
        D_AWREADY   = M_AWREADY && !aw_done_reg;
        D_WREADY    = M_WREADY && !w_done_reg;
        aw_done_now = aw_done_reg || M_AWREADY;
        w_done_now  = w_done_reg || M_WREADY;
        if (aw_done_now && w_done_now) begin
          state_next   = S_WRESP;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          aw_done_next = aw_done_now;
          w_done_next  = w_done_now;
        end
      end

      S_WRESP: begin
        D_BVALID = M_BVALID;
        D_BRESP  = M_BRESP;
        M_BREADY = D_BREADY;
        if (M_BVALID && D_BREADY) begin
          state_next = S_IDLE;
          grant_next = GRANT_NONE;
        end
      end

      default: begin
        state_next = S_IDLE;
        grant_next = GRANT_NONE;
      end
    endcase
  end

  assign M_ARADDR = addr_reg;
  assign M_AWADDR = addr_reg;
  assign M_WDATA  = wdata_reg;
  assign M_WSTRB  = wstrb_reg;
  assign GRANT    = grant_reg;
  assign BUSY     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_core_axi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_axi_arbiter
// Directed stimulus with a scoreboard: the stimulus thread pushes expected M-port
// requests and requester responses into queues; a separate monitor pops and
// compares on every handshake. A behavioural memory slave answers the M port
// with configurable wait cycles.
// -----------------------------------------------------------------------------
module tb_core_axi_arbiter;
  import core_axi_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        I_ARVALID;
  logic [31:0] I_ARADDR;
  logic        I_ARREADY;
  logic        I_RVALID;
  logic [31:0] I_RDATA;
  logic [1:0]  I_RRESP;
  logic        I_RREADY;
  logic        D_ARVALID;
  logic [31:0] D_ARADDR;
  logic        D_ARREADY;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic [1:0]  D_RRESP;
  logic        D_RREADY;
  logic        D_AWVALID;
  logic [31:0] D_AWADDR;
  logic        D_AWREADY;
  logic        D_WVALID;
  logic [31:0] D_WDATA;
  logic [3:0]  D_WSTRB;
  logic        D_WREADY;
  logic        D_BVALID;
  logic [1:0]  D_BRESP;
  logic        D_BREADY;
  logic        M_ARVALID;
  logic [31:0] M_ARADDR;
  logic        M_ARREADY;
  logic        M_RVALID;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RREADY;
  logic        M_AWVALID;
  logic [31:0] M_AWADDR;
  logic        M_AWREADY;
  logic        M_WVALID;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WREADY;
  logic        M_BVALID;
  logic [1:0]  M_BRESP;
  logic        M_BREADY;
  logic [1:0]  GRANT;
  logic        BUSY;

  core_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .NRST(NRST),
    .I_ARVALID(I_ARVALID), .I_ARADDR(I_ARADDR), .I_ARREADY(I_ARREADY),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA), .I_RRESP(I_RRESP), .I_RREADY(I_RREADY),
    .D_ARVALID(D_ARVALID), .D_ARADDR(D_ARADDR), .D_ARREADY(D_ARREADY),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .D_RRESP(D_RRESP), .D_RREADY(D_RREADY),
    .D_AWVALID(D_AWVALID), .D_AWADDR(D_AWADDR), .D_AWREADY(D_AWREADY),
    .D_WVALID(D_WVALID), .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB), .D_WREADY(D_WREADY),
    .D_BVALID(D_BVALID), .D_BRESP(D_BRESP), .D_BREADY(D_BREADY),
    .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_ARREADY(M_ARREADY),
    .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RREADY(M_RREADY),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BRESP(M_BRESP), .M_BREADY(M_BREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; logic [1:0] grant; } ar_t;
  typedef struct { int kind; logic [31:0] data; logic [1:0] resp; } resp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;

  ar_t         exp_ar[$];
  resp_t       exp_resp[$];
  logic [31:0] exp_aw[$];
  w_t          exp_w[$];

  int errors = 0;
  int checks = 0;
  int n_ar_hs = 0;

  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  // Memory contents seen by the slave model.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h0000_0013;
      32'h0000_0200: return 32'hCAFE_0200;
      32'h0000_0300: return 32'hBEEF_0300;
      32'h0000_0400: return 32'h1111_0400;
      32'h0000_0500: return 32'h2222_0500;
      32'h0000_0600: return 32'hBAD0_0600;
      32'h0000_0800: return 32'h8888_0800;
      default:       return 32'h0;
    endcase
  endfunction

  // ---------------- read slave ----------------
  initial begin
    int rs, rcnt;
    logic r_hs;
    logic [31:0] rd_addr;
    rs = 0; rcnt = 0; rd_addr = '0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = '0; M_RRESP = RESP_OKAY;
    forever begin
      @(negedge CLK);
      r_hs = M_RVALID && M_RREADY;
      @(posedge CLK);
      #1;
      if (!NRST) begin
        rs = 0; M_ARREADY = 0; M_RVALID = 0;
      end else begin
        if (rs == 0 && M_ARVALID) begin rs = 1; rcnt = 0; end
        case (rs)
          1: if (rcnt >= ar_wait) begin
               M_ARREADY = 1; rd_addr = M_ARADDR; rs = 2; rcnt = 0;
             end else rcnt++;
          2: begin
               M_ARREADY = 0;
               if (rcnt >= r_wait) begin
                 M_RVALID = 1; M_RDATA = rd_model(rd_addr);
                 M_RRESP = (rd_addr == 32'h600) ? RESP_SLVERR : RESP_OKAY;
                 rs = 3;
               end else rcnt++;
             end
          3: if (r_hs) begin M_RVALID = 0; rs = 0; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- write slave ----------------
  initial begin
    int ws, wcnt;
    logic b_hs;
    ws = 0; wcnt = 0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = RESP_OKAY;
    forever begin
      @(negedge CLK);
      b_hs = M_BVALID && M_BREADY;
      @(posedge CLK);
      #1;
      if (!NRST) begin
        ws = 0; M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0;
      end else begin
        if (ws == 0 && M_AWVALID) begin ws = 1; wcnt = 0; end
        case (ws)
          1: begin
               M_AWREADY = (wcnt == aw_wait);
               M_WREADY  = (wcnt == w_wait);
               if (wcnt >= aw_wait && wcnt >= w_wait) begin ws = 2; wcnt = 0; end
               else wcnt++;
             end
          2: begin
               M_AWREADY = 0; M_WREADY = 0;
               if (wcnt >= b_wait) begin M_BVALID = 1; M_BRESP = RESP_OKAY; ws = 3; end
               else wcnt++;
             end
          3: if (b_hs) begin M_BVALID = 0; ws = 0; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    ar_t a; resp_t r; w_t w; logic [31:0] aw;
    forever begin
      @(negedge CLK);
      if (NRST) begin
        if (M_ARVALID && M_ARREADY) begin
          n_ar_hs++;
          if (exp_ar.size() == 0) fail_now("unexpected_ar");
          else begin
            a = exp_ar.pop_front();
            check("ar_addr", M_ARADDR, a.addr);
            check("ar_grant", {30'd0, GRANT}, {30'd0, a.grant});
            $display("txn AR addr=%h grant=%b", M_ARADDR, GRANT);
          end
        end
        if (M_AWVALID && M_AWREADY) begin
          if (exp_aw.size() == 0) fail_now("unexpected_aw");
          else begin
            aw = exp_aw.pop_front();
            check("aw_addr", M_AWADDR, aw);
            $display("txn AW addr=%h", M_AWADDR);
          end
        end
        if (M_WVALID && M_WREADY) begin
          if (exp_w.size() == 0) fail_now("unexpected_w");
          else begin
            w = exp_w.pop_front();
            check("w_data", M_WDATA, w.data);
            check("w_strb", {28'd0, M_WSTRB}, {28'd0, w.strb});
            $display("txn W data=%h strb=%b", M_WDATA, M_WSTRB);
          end
        end
        if (I_RVALID && I_RREADY) begin
          if (exp_resp.size() == 0) fail_now("unexpected_i_r");
          else begin
            r = exp_resp.pop_front();
            check("i_r_kind", 32'd1, r.kind);
            check("i_rdata", I_RDATA, r.data);
            check("i_rresp", {30'd0, I_RRESP}, {30'd0, r.resp});
            $display("txn I_R data=%h resp=%b", I_RDATA, I_RRESP);
          end
        end
        if (D_RVALID && D_RREADY) begin
          if (exp_resp.size() == 0) fail_now("unexpected_d_r");
          else begin
            r = exp_resp.pop_front();
            check("d_r_kind", 32'd2, r.kind);
            check("d_rdata", D_RDATA, r.data);
            check("d_rresp", {30'd0, D_RRESP}, {30'd0, r.resp});
            $display("txn D_R data=%h resp=%b", D_RDATA, D_RRESP);
          end
        end
        if (D_BVALID && D_BREADY) begin
          if (exp_resp.size() == 0) fail_now("unexpected_d_b");
          else begin
            r = exp_resp.pop_front();
            check("d_b_kind", 32'd3, r.kind);
            check("d_bresp", {30'd0, D_BRESP}, {30'd0, r.resp});
            $display("txn D_B resp=%b", D_BRESP);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance one cycle; drop requester valids that handshook at this edge.
  task automatic tick();
    logic i_hs, dr_hs, daw_hs, dw_hs;
    @(negedge CLK);
    i_hs   = I_ARVALID && I_ARREADY;
    dr_hs  = D_ARVALID && D_ARREADY;
    daw_hs = D_AWVALID && D_AWREADY;
    dw_hs  = D_WVALID && D_WREADY;
    @(posedge CLK);
    #1;
    if (i_hs)   I_ARVALID = 0;
    if (dr_hs)  D_ARVALID = 0;
    if (daw_hs) D_AWVALID = 0;
    if (dw_hs)  D_WVALID = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((BUSY || I_ARVALID || D_ARVALID || D_AWVALID || D_WVALID ||
            exp_resp.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now(nm);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [1:0] g);
    ar_t e; e.addr = a; e.grant = g; exp_ar.push_back(e);
  endtask

  task automatic push_resp(input int k, input logic [31:0] d, input logic [1:0] r);
    resp_t e; e.kind = k; e.data = d; e.resp = r; exp_resp.push_back(e);
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s);
    w_t e; e.data = d; e.strb = s; exp_w.push_back(e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    NRST = 0;
    I_ARVALID = 0; I_ARADDR = '0; I_RREADY = 1;
    D_ARVALID = 0; D_ARADDR = '0; D_RREADY = 1;
    D_AWVALID = 0; D_AWADDR = '0; D_WVALID = 0; D_WDATA = '0; D_WSTRB = '0;
    D_BREADY = 1;
    repeat (3) tick();
    settle();
    check("rst_busy", BUSY, 0);
    check("rst_grant", GRANT, 0);
    check("rst_m_arvalid", M_ARVALID, 0);
    check("rst_m_awvalid", M_AWVALID, 0);
    NRST = 1;
    tick(); settle();
    check("idle_busy", BUSY, 0);
    check("idle_grant", GRANT, 0);

    // Single fetch, two R wait cycles: 5 cycles total.
    ar_wait = 0; r_wait = 2;
    push_ar(32'h40, GRANT_INSTR);
    push_resp(1, 32'h0000_0013, RESP_OKAY);
    I_ARVALID = 1; I_ARADDR = 32'h40;
    n = 0;
    do begin
      tick(); n++; settle();
      check("fetch_d_rvalid", D_RVALID, 0);
      check("fetch_d_arready", D_ARREADY, 0);
      if (BUSY) check("fetch_grant", GRANT, GRANT_INSTR);
    end while (BUSY && n < 50);
    check("fetch_cycles", n, 5);
    r_wait = 0;

    // Collision after an instruction grant: data first in both policies.
    push_ar(32'h300, GRANT_DREAD);
    push_resp(2, 32'hBEEF_0300, RESP_OKAY);
    push_ar(32'h200, GRANT_INSTR);
    push_resp(1, 32'hCAFE_0200, RESP_OKAY);
    I_ARVALID = 1; I_ARADDR = 32'h200;
    D_ARVALID = 1; D_ARADDR = 32'h300;
    tick(); settle();
    check("coll1_grant", GRANT, GRANT_DREAD);
    check("coll1_i_arready", I_ARREADY, 0);
    tick(); settle();
    check("coll1_i_held", I_ARVALID, 1);
    check("coll1_i_rvalid", I_RVALID, 0);
    wait_done("coll1_timeout");

    // Lone data read so the last grant is data, then collide again.
    push_ar(32'h500, GRANT_DREAD);
    push_resp(2, 32'h2222_0500, RESP_OKAY);
    D_ARVALID = 1; D_ARADDR = 32'h500;
    wait_done("dread_timeout");
`ifdef ARB_ROUND_ROBIN_EN
    push_ar(32'h200, GRANT_INSTR);
    push_resp(1, 32'hCAFE_0200, RESP_OKAY);
    push_ar(32'h300, GRANT_DREAD);
    push_resp(2, 32'hBEEF_0300, RESP_OKAY);
`else
    push_ar(32'h300, GRANT_DREAD);
    push_resp(2, 32'hBEEF_0300, RESP_OKAY);
    push_ar(32'h200, GRANT_INSTR);
    push_resp(1, 32'hCAFE_0200, RESP_OKAY);
`endif
    I_ARVALID = 1; I_ARADDR = 32'h200;
    D_ARVALID = 1; D_ARADDR = 32'h300;
    wait_done("coll2_timeout");

    // Store: AWREADY in cycle 1, WREADY in cycle 3.
    aw_wait = 0; w_wait = 2; b_wait = 0;
    exp_aw.push_back(32'h100);
    push_w(32'hDEAD_BEEF, 4'b1111);
    push_resp(3, 32'h0, RESP_OKAY);
    D_AWVALID = 1; D_AWADDR = 32'h100;
    D_WVALID = 1; D_WDATA = 32'hDEAD_BEEF; D_WSTRB = 4'b1111;
    tick(); settle();
    check("st_c1_grant", GRANT, GRANT_DWRITE);
    check("st_c1_awvalid", M_AWVALID, 1);
    check("st_c1_awready", D_AWREADY, 1);
    check("st_c1_wready", D_WREADY, 0);
    check("st_c1_bready", M_BREADY, 0);
    tick(); settle();
    check("st_c2_awvalid", M_AWVALID, 0);
    check("st_c2_wvalid", M_WVALID, 1);
    check("st_c2_bready", M_BREADY, 0);
    tick(); settle();
    check("st_c3_wready", D_WREADY, 1);
    check("st_c3_bready", M_BREADY, 0);
    tick(); settle();
    check("st_c4_bready", M_BREADY, 1);
    check("st_c4_bvalid", D_BVALID, 1);
    wait_done("store_timeout");
    w_wait = 0;

    // Back-pressure: D_RREADY low for 4 cycles while M_RVALID is up.
    push_ar(32'h400, GRANT_DREAD);
    push_resp(2, 32'h1111_0400, RESP_OKAY);
    D_RREADY = 0;
    D_ARVALID = 1; D_ARADDR = 32'h400;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check("bp_m_rready", M_RREADY, 0);
      check("bp_busy", BUSY, 1);
      check("bp_d_rvalid", D_RVALID, 1);
    end
    D_RREADY = 1;
    wait_done("bp_timeout");

    // Slave error passed through, no retry.
    push_ar(32'h600, GRANT_DREAD);
    push_resp(2, 32'hBAD0_0600, RESP_SLVERR);
    D_ARVALID = 1; D_ARADDR = 32'h600;
    wait_done("slverr_timeout");
    repeat (3) tick();
    settle();
    check("slverr_idle", BUSY, 0);
    check("slverr_no_retry", M_ARVALID, 0);

    // Reset during S_WRESP with a fetch pending.
    b_wait = 30;
    exp_aw.push_back(32'h700);
    push_w(32'h0102_0304, 4'b0011);
    D_AWVALID = 1; D_AWADDR = 32'h700;
    D_WVALID = 1; D_WDATA = 32'h0102_0304; D_WSTRB = 4'b0011;
    tick(); tick();
    I_ARVALID = 1; I_ARADDR = 32'h800;
    tick(); settle();
    check("wr_in_wresp", M_BREADY, 1);
    check("wr_i_arready", I_ARREADY, 0);
    NRST = 0;
    #1;
    check("nrst_busy", BUSY, 0);
    check("nrst_grant", GRANT, 0);
    check("nrst_m_arvalid", M_ARVALID, 0);
    check("nrst_m_awvalid", M_AWVALID, 0);
    check("nrst_m_wvalid", M_WVALID, 0);
    check("nrst_m_bready", M_BREADY, 0);
    check("nrst_d_bvalid", D_BVALID, 0);
    check("nrst_i_arready", I_ARREADY, 0);
    tick(); tick();
    b_wait = 0;
    push_ar(32'h800, GRANT_INSTR);
    push_resp(1, 32'h8888_0800, RESP_OKAY);
    NRST = 1;
    tick(); settle();
    check("post_rst_grant", GRANT, GRANT_INSTR);
    check("post_rst_busy", BUSY, 1);
    wait_done("post_rst_timeout");

    repeat (2) tick();
    check("ar_count", n_ar_hs, 9);
    check("left_ar", exp_ar.size(), 0);
    check("left_aw", exp_aw.size(), 0);
    check("left_w", exp_w.size(), 0);
    check("left_resp", exp_resp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
